// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//
// Shared 640x480@60 Hz raster definition. The renderer, the game logic and
// the sync generator all take the screen size from here, so there is exactly
// one place that says how big the visible area is.
//
// Contents:
//   VGA_H_* / VGA_V_*   default horizontal (pixels) and vertical (lines) timing
//   VGA_H_TOTAL/V_TOTAL derived raster totals (800 x 525)
//   VGA_CNT_W           counter width, wide enough for both totals minus one
//   vga_coord_t         convenience type for a raster coordinate
//   axis_total()        sum of the four segments of one axis
//   in_window()         half-open range test used by the sync/active decoders
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_CNT_W    = 10;

    typedef logic [VGA_CNT_W-1:0] vga_coord_t;

    // Number of positions along one axis (active + porches + sync).
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // True when first <= value < first + len.
    function automatic logic in_window(input int value, input int first,
                                       input int len);
        return (value >= first) && (value < first + len);
    endfunction

endpackage

// File: rtl/sync_axis_counter.sv
// -----------------------------------------------------------------------------
// sync_axis_counter
//
// One raster axis: a wrapping position counter plus registered decodes of
// the sync pulse and the active region. Instantiated once for the horizontal
// axis (advancing on every pixel strobe) and once for the vertical axis
// (advancing only when the horizontal axis wraps).
//
// The axis is laid out as  ACTIVE | FP | SYNC | BP  and counts 0..TOTAL-1.
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-low reset
//   en      advance enable (one step per clk while high)
//   cnt     current position, 0..TOTAL-1
//   wrap    high while cnt sits on TOTAL-1 (the next enabled step returns to 0)
//   sync_n  active-low sync, low while cnt is inside the SYNC segment
//   active  high while cnt is inside the ACTIVE segment
// -----------------------------------------------------------------------------
module sync_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter int CNT_W  = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             sync_n,
    output logic             active
);

    localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_START = ACTIVE + FP;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    // Reset parks the axis on its last position; the decodes for that
    // position are computed here so the reset values are consistent with
    // what the decoder would produce there (no sync, not active for VGA).
    localparam logic RST_SYNC_N = !in_window(TOTAL - 1, SYNC_START, SYNC);
    localparam logic RST_ACTIVE = in_window(TOTAL - 1, 0, ACTIVE);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             sync_n_reg;
    logic             sync_n_next;
    logic             active_reg;
    logic             active_next;

    assign wrap = (cnt_reg == LAST);

    // The sync/active flags are decoded from the value the counter is about
    // to take, so after the edge they describe the count on the output with
    // no extra cycle of lag.
    always_comb begin
        cnt_next    = cnt_reg;
        sync_n_next = sync_n_reg;
        active_next = active_reg;
        if (en) begin
            cnt_next    = wrap ? '0 : cnt_reg + 1'b1;
            sync_n_next = !in_window(int'(cnt_next), SYNC_START, SYNC);
            active_next = in_window(int'(cnt_next), 0, ACTIVE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg    <= LAST;
            sync_n_reg <= RST_SYNC_N;
            active_reg <= RST_ACTIVE;
        end else begin
            cnt_reg    <= cnt_next;
            sync_n_reg <= sync_n_next;
            active_reg <= active_next;
        end
    end

    assign cnt    = cnt_reg;
    assign sync_n = sync_n_reg;
    assign active = active_reg;

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//
// 640x480@60 Hz raster timing generator. Runs on the system clock and uses
// the clock divider's one-cycle pixel strobe as a clock enable. Out of reset
// the raster sits on its last position (799,524), so the first strobe lands
// on (0,0).
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   pix_en      one-cycle pixel strobe (may also be held high continuously)
//   x, y        current raster position
//   video_on    high while (x,y) is inside the visible area
//   hsync       active-low horizontal sync
//   vsync       active-low vertical sync
//   frame_tick  one-clk pulse when the raster enters vertical blanking,
//               i.e. in the cycle (x,y) becomes (0,V_ACTIVE)
//
// x, y, hsync, vsync and the two axis-active flags are all flops that update
// on the same edge, so every output describes the same raster position.
// -----------------------------------------------------------------------------
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int CNT_W    = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_tick
);

    // Last visible line: leaving it (on a horizontal wrap) is the moment
    // the raster enters vertical blanking.
    localparam logic [CNT_W-1:0] LAST_ACTIVE_LINE = CNT_W'(V_ACTIVE - 1);

    logic             h_wrap;
    logic             h_active;
    logic             v_en;
    logic             v_active;
    logic             unused_v_wrap;
    logic [CNT_W-1:0] x_cnt;
    logic [CNT_W-1:0] y_cnt;
    logic             frame_tick_reg;
    logic             frame_tick_next;

    // Horizontal axis steps on every pixel strobe.
    sync_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .en     (pix_en),
        .cnt    (x_cnt),
        .wrap   (h_wrap),
        .sync_n (hsync),
        .active (h_active)
    );

    // Vertical axis steps only on the strobe that wraps the line, which
    // makes it wrap together with x at the end of the frame.
    assign v_en = pix_en & h_wrap;

    // The vertical wrap is not needed here: the frame boundary that matters
    // to game logic is the entry to blanking, not the return to line 0.
    sync_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .en     (v_en),
        .cnt    (y_cnt),
        .wrap   (unused_v_wrap),
        .sync_n (vsync),
        .active (v_active)
    );

    // Fires on the strobe that moves (x,y) from the end of the last visible
    // line to (0,V_ACTIVE). Any cycle without a strobe clears it, so the
    // pulse is one clk wide even when pix_en is held high.
    always_comb begin
        frame_tick_next = 1'b0;
        if (v_en && (y_cnt == LAST_ACTIVE_LINE)) begin
            frame_tick_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_tick_reg <= 1'b0;
        end else begin
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign x          = x_cnt;
    assign y          = y_cnt;
    // Both flags are flops updated on the same edge as x/y.
    assign video_on   = h_active & v_active;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Two instances: dut_a with the default 640x480 timing, dut_b with a tiny
// raster (15 x 13) so whole frames, vsync and frame_tick fit in a short run.
// The reference model keeps only a linear raster index per instance
// (0 .. H_TOTAL*V_TOTAL-1); expected x, y and flags are derived from it with
// division, modulo and range tests.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

    localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
    localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
    localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
    localparam int A_PIX = A_HT * A_VT;

    localparam int B_HA = 8, B_HF = 2, B_HS = 3, B_HB = 2;
    localparam int B_VA = 6, B_VF = 2, B_VS = 2, B_VB = 3;
    localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
    localparam int B_VT = B_VA + B_VF + B_VS + B_VB;
    localparam int B_PIX = B_HT * B_VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, en_a, en_b;
    logic [9:0] xa, ya, xb, yb;
    logic       von_a, hs_a, vs_a, ft_a;
    logic       von_b, hs_b, vs_b, ft_b;

    vga_sync_gen dut_a (
        .clk(clk), .rst(rst_a), .pix_en(en_a), .x(xa), .y(ya),
        .video_on(von_a), .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a)
    );

    vga_sync_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .CNT_W(10)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pix_en(en_b), .x(xb), .y(yb),
        .video_on(von_b), .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pa, pb;          // model raster index per instance
    bit fte_a, fte_b;    // model frame_tick per instance

    function automatic bit win(input int v, input int lo, input int n);
        return (v >= lo) && (v < lo + n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_x",          xa,    pa % A_HT);
        chk("a_y",          ya,    pa / A_HT);
        chk("a_video_on",   von_a, (pa % A_HT < A_HA) && (pa / A_HT < A_VA));
        chk("a_hsync",      hs_a,  !win(pa % A_HT, A_HA + A_HF, A_HS));
        chk("a_vsync",      vs_a,  !win(pa / A_HT, A_VA + A_VF, A_VS));
        chk("a_frame_tick", ft_a,  fte_a);
        chk("b_x",          xb,    pb % B_HT);
        chk("b_y",          yb,    pb / B_HT);
        chk("b_video_on",   von_b, (pb % B_HT < B_HA) && (pb / B_HT < B_VA));
        chk("b_hsync",      hs_b,  !win(pb % B_HT, B_HA + B_HF, B_HS));
        chk("b_vsync",      vs_b,  !win(pb / B_HT, B_VA + B_VF, B_VS));
        chk("b_frame_tick", ft_b,  fte_b);
    endtask

    // One clock: advance the model by what the DUT saw at the edge, then
    // compare 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_a) begin
            pa = A_PIX - 1; fte_a = 0;
        end else if (en_a) begin
            pa = (pa + 1) % A_PIX; fte_a = (pa == A_VA * A_HT);
        end else begin
            fte_a = 0;
        end
        if (!rst_b) begin
            pb = B_PIX - 1; fte_b = 0;
        end else if (en_b) begin
            pb = (pb + 1) % B_PIX; fte_b = (pb == B_VA * B_HT);
        end else begin
            fte_b = 0;
        end
        check_all();
    endtask

    initial begin
        int cnt_hs, cnt_blank, cnt_vs, ticks, since, last_tick;

        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
        pa = A_PIX - 1; pb = B_PIX - 1; fte_a = 0; fte_b = 0;
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check_all();                 // reset values before any clock edge
        repeat (3) tick();
        rst_a = 1'b1;

        // Strobe every 4th clk: first strobe lands on (0,0), outputs hold between.
        cnt_hs = 0; cnt_blank = 0;
        for (int i = 0; i < 8; i++) begin
            en_a = 1'b1;
            tick();
            if (i == 0) begin
                chk("a_first_strobe_x", xa, 0);
                chk("a_first_strobe_video_on", von_a, 1);
            end
            if (pa < A_HT && hs_a === 1'b0) cnt_hs++;
            if (pa < A_HT && von_a === 1'b0) cnt_blank++;
            en_a = 1'b0;
            repeat (3) tick();
        end

        // Rest of line 0 with random strobes.
        for (int i = 0; i < 6000 && pa != A_HT; i++) begin
            en_a = ($urandom_range(0, 3) != 0);
            tick();
            if (en_a && pa < A_HT && hs_a === 1'b0) cnt_hs++;
            if (en_a && pa < A_HT && von_a === 1'b0) cnt_blank++;
        end
        en_a = 1'b0;
        chk("a_line0_hsync_low_strobes", cnt_hs, A_HS);
        chk("a_line0_blank_strobes", cnt_blank, A_HF + A_HS + A_HB);
        chk("a_y_after_line0", ya, 1);

        // Hold pix_en low for 100 clks at x=300.
        for (int i = 0; i < 3000 && pa != A_HT + 300; i++) begin
            en_a = ($urandom_range(0, 3) != 0);
            tick();
        end
        en_a = 1'b0;
        repeat (100) tick();
        chk("a_hold_x", xa, 300);
        chk("a_hold_frame_tick", ft_a, 0);

        // Asynchronous reset in the middle of hsync at x=700.
        for (int i = 0; i < 6000 && pa != 3 * A_HT + 700; i++) begin
            en_a = ($urandom_range(0, 3) != 0);
            tick();
        end
        en_a = 1'b0;
        chk("a_pre_reset_hsync", hs_a, 0);
        #2;
        rst_a = 1'b0;
        #1;
        pa = A_PIX - 1; fte_a = 0;
        check_all();
        tick();
        rst_a = 1'b1;
        for (int i = 0; i < 60; i++) begin
            en_a = $urandom_range(0, 1);
            tick();
        end
        en_a = 1'b0;

        // Small raster: three frames with pix_en held high.
        rst_b = 1'b1; en_b = 1'b1;
        cnt_vs = 0; ticks = 0; last_tick = -1;
        for (int i = 0; i < 3 * B_PIX; i++) begin
            tick();
            if (vs_b === 1'b0) cnt_vs++;
            if (ft_b === 1'b1) begin
                ticks++;
                if (last_tick >= 0) chk("b_tick_spacing_const", i - last_tick, B_PIX);
                last_tick = i;
            end
        end
        chk("b_vsync_low_clks", cnt_vs, 3 * B_VS * B_HT);
        chk("b_tick_count_const", ticks, 3);
        chk("b_frame_end_x", xb, B_HT - 1);

        // Three more frames with random strobes; spacing counted in strobes.
        ticks = 0;
        since = (pb - B_VA * B_HT + B_PIX) % B_PIX;
        for (int i = 0; i < 4000 && ticks < 3; i++) begin
            en_b = $urandom_range(0, 1);
            tick();
            if (en_b) since++;
            if (ft_b === 1'b1) begin
                ticks++;
                chk("b_tick_spacing_rand", since, B_PIX);
                since = 0;
            end
        end
        chk("b_tick_count_rand", ticks, 3);

        // Asynchronous reset inside both hsync and vsync (x=11, y=8).
        for (int i = 0; i < 1000 && pb != 8 * B_HT + 11; i++) begin
            en_b = 1'b1;
            tick();
        end
        en_b = 1'b0;
        chk("b_pre_reset_hsync", hs_b, 0);
        chk("b_pre_reset_vsync", vs_b, 0);
        #2;
        rst_b = 1'b0;
        #1;
        pb = B_PIX - 1; fte_b = 0;
        check_all();
        tick();
        rst_b = 1'b1;
        for (int i = 0; i < 3 * B_PIX; i++) begin
            en_b = $urandom_range(0, 1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing for the snake display.
- Sits directly downstream of the clock divider and consumes its one-cycle pixel strobe as a clock enable; the whole block runs on the single system clock.
- Provides pixel coordinates and an active-video flag to the renderer, sync pulses to the pins, and a per-frame tick to game logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CNT_W, 10, width of the x/y counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk, input, 1, system clock
- rst, input, 1, asynchronous active-low reset
- pix_en, input, 1, one-cycle pixel strobe from the clock divider
- x, output, CNT_W, current horizontal position
- y, output, CNT_W, current vertical position
- video_on, output, 1, high when x < H_ACTIVE and y < V_ACTIVE
- hsync, output, 1, active-low horizontal sync
- vsync, output, 1, active-low vertical sync
- frame_tick, output, 1, one-clk pulse on entry to vertical blanking

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset (rst low, asynchronous): x=H_TOTAL-1 (799), y=V_TOTAL-1 (524), video_on=0, hsync=1, vsync=1, frame_tick=0.
- Reset state is the last raster position, so the first pix_en after reset lands on (0,0).
- All outputs are registered. On a clk edge with pix_en=0, every output holds, except frame_tick, which is forced to 0.
- On a clk edge with pix_en=1:
  - x advances by 1; when x == H_TOTAL-1 it wraps to 0.
  - y advances by 1 only when x wraps; when y == V_TOTAL-1 it wraps to 0 in that same cycle.
- hsync, vsync and video_on are decoded from the next x/y values and registered on the same edge, so they always describe the x/y currently on the outputs. There is no pipeline skew.
- hsync=0 iff H_ACTIVE+H_FP <= x <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
- vsync=0 iff V_ACTIVE+V_FP <= y <= V_ACTIVE+V_FP+V_SYNC-1 (490..491).
- frame_tick=1 for exactly one clk, in the cycle where (x,y) becomes (0,V_ACTIVE). It is never asserted in any other cycle.
- pix_en held high continuously is legal: counters advance every clk and the timing stays correct, only faster.
- Reset asserted mid-frame: all outputs return to their reset values immediately and asynchronously. After release, counting restarts from (799,524) with no partial sync pulse glitch.
- x and y never exceed H_TOTAL-1 and V_TOTAL-1. There are no other counter states.

Decomposition:
- vga_timing_pkg holds the default timing constants, the derived H_TOTAL/V_TOTAL, and CNT_W, so the renderer and the game logic share one definition of the screen size.
- One sub-module, sync_axis_counter, is instantiated twice (horizontal and vertical). It has parameters ACTIVE, FP, SYNC, BP and ports clk, rst, en, cnt, wrap, sync_n, active.
  - The horizontal instance's en is pix_en.
  - The vertical instance's en is pix_en AND the horizontal instance's wrap.

Test Plan:
- Reset, then release with pix_en pulsed every 4th clk -> after 1st pix_en (x,y)=(0,0), video_on=1, hsync=1, vsync=1; outputs hold for the 3 clks between pulses.
- Run 800 pix_en on line 0 -> hsync low for exactly 96 strobes, x=656..751; video_on low from x=640; y increments to 1 on the 800th strobe.
- Run a full frame with pix_en always high -> vsync low for exactly 1600 clks (y=490..491); frame_tick is a single 1-clk pulse at (0,480); next frame starts at (0,0) after 420000 strobes.
- Count frame_tick over 3 frames -> exactly 3 pulses, spaced 420000 pix_en apart.
- Assert rst at (x,y)=(700,490) during hsync and vsync -> hsync, vsync and video_on go to 1, 1, 0 without waiting for clk; x=799, y=524.
- Hold pix_en=0 for 100 clks mid-line at x=300 -> x, y, hsync, vsync and video_on unchanged; frame_tick stays 0.
